// File: rtl/pico_wb_master_pkg.sv
// Shared definitions for the picorv32-to-Wishbone bridge: FSM states and bus constants.
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } wb_state_e;

  localparam logic [3:0]  WB_SEL_ALL          = 4'hF;
  localparam logic [31:0] WB_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int unsigned WB_TMO_W            = 16;

endpackage

// File: rtl/pico_wb_master_if.sv
// Bundles the CPU native memory bus and the Wishbone classic master signals.
interface pico_wb_master_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_hit;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;

  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  // Bridge side.
  modport master (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output mem_hit, mem_ready_o, mem_rdata_o,
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );

  // CPU and fabric side.
  modport slave (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  mem_hit, mem_ready_o, mem_rdata_o,
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );

endinterface

// File: rtl/pico_wb_master_timeout_ctr.sv
// Bus watchdog: counts REQ cycles and flags the last allowed cycle. TIMEOUT_CYCLES=0 disables it.
module wb_timeout_ctr
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock_main,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WB_TMO_W-1:0] Limit   = WB_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam bit                  Enabled = (TIMEOUT_CYCLES != 0);

  logic [WB_TMO_W-1:0] cnt_q, cnt_d;

  // Clear on request start, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WB_TMO_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock_main) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = Enabled && en && (cnt_q == Limit);

endmodule

// File: rtl/pico_wb_master.sv
// Bridge from the picorv32 native memory bus to one Wishbone classic master port,
// with address window decode, error termination, watchdog and error capture.
module pico_wb_master
  import wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFF00_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = WB_ERR_DATA_DEFAULT
) (
  input  logic                    clock_main,
  input  logic                    rst_n,
  pico_wb_master_if.master        bus,
  input  logic                    err_clr,
  output logic                    err_sticky,
  output logic                    err_timeout,
  output logic [31:0]             err_addr,
  output logic                    err_irq
);

  wb_state_e   state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sticky_q, sticky_d;
  logic        timeout_q, timeout_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic        irq_q, irq_d;

  logic hit;
  logic tmo_clr;
  logic tmo_expire;
  logic log_err;
  logic log_tmo;

  assign hit = bus.mem_valid && ((bus.mem_addr & ADDR_MASK) == BASE_ADDR);

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock_main(clock_main),
    .rst_n     (rst_n),
    .clr       (tmo_clr),
    .en        (state_q == StReq),
    .expire    (tmo_expire)
  );

  // Request FSM: latch on hit, wait for err/ack/watchdog, then one ready cycle.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    tmo_clr = 1'b0;
    log_err = 1'b0;
    log_tmo = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StReq;
          adr_d   = bus.mem_addr;
          dat_d   = bus.mem_wdata;
          we_d    = |bus.mem_wstrb;
          sel_d   = (|bus.mem_wstrb) ? bus.mem_wstrb : WB_SEL_ALL;
          tmo_clr = 1'b1;
        end
      end
      StReq: begin
        // err beats ack; the watchdog only fires when the slave stayed silent.
        if (bus.wbm_err_i) begin
          rdata_d = ERR_DATA;
          log_err = 1'b1;
          we_d    = 1'b0;
          state_d = StDone;
        end else if (bus.wbm_ack_i) begin
          rdata_d = we_q ? '0 : bus.wbm_dat_i;
          we_d    = 1'b0;
          state_d = StDone;
        end else if (tmo_expire) begin
          rdata_d = ERR_DATA;
          log_tmo = 1'b1;
          we_d    = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Error capture: a new error always sets sticky; capture only the first since clear.
  always_comb begin
    irq_d     = log_err || log_tmo;
    sticky_d  = sticky_q;
    timeout_d = timeout_q;
    eaddr_d   = eaddr_q;
    if (log_err || log_tmo) begin
      sticky_d = 1'b1;
      if (!sticky_q || err_clr) begin
        timeout_d = log_tmo;
        eaddr_d   = adr_q;
      end
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clock_main) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      rdata_q   <= '0;
      sticky_q  <= 1'b0;
      timeout_q <= 1'b0;
      eaddr_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      sticky_q  <= sticky_d;
      timeout_q <= timeout_d;
      eaddr_q   <= eaddr_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.mem_hit     = hit;
  assign bus.mem_ready_o = (state_q == StDone);
  assign bus.mem_rdata_o = (state_q == StDone) ? rdata_q : '0;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_stb_o   = (state_q == StReq);
  assign bus.wbm_cyc_o   = (state_q == StReq);

  assign err_sticky  = sticky_q;
  assign err_timeout = timeout_q;
  assign err_addr    = eaddr_q;
  assign err_irq     = irq_q;

endmodule
